oled_string_renderer: RTL and testbench
=======================================

// Module: oled_string_renderer
// PURPOSE
//  Reads glyph columns from OLED_FontData and streams an SSD1306-style cmd/data byte sequence to the OLED writer.
//  Draws a string of up to MAX_CHARS glyphs (8x16 narrow or 16x16 wide) as two pages (font_row 0 then 1).
//  Sits between the display-content controller (string source) and the OLED byte/SPI writer.
// PARAMETERS
//  MAX_CHARS  16   max glyphs per request; sets width of num_chars and char_idx
//  OLED_COLS  128  display width; the column limit used for clipping
// PORTS
//  sys_clk    in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  start      in   1  1-cycle request pulse; sampled only in IDLE
//  page       in   3  top page of the string (row 0 -> page, row 1 -> page+1)
//  col        in   7  start column
//  num_chars  in   5  glyph count, 0..MAX_CHARS
//  char_idx   out  5  index of the current glyph in the caller's string
//  char_code  in   6  font_sel code for char_idx; combinational from caller
//  char_wide  in   1  1 = 16-wide glyph, 0 = 8-wide; combinational with char_code
//  font_sel   out  6  to font ROM (registered)
//  font_row   out  1  to font ROM (registered)
//  index      out  9  glyph column to font ROM (registered)
//  font_data  in   8  font ROM output; 1-cycle registered latency
//  out_valid  out  1  byte available
//  out_ready  in   1  writer accepts; transfer = out_valid & out_ready
//  out_byte   out  8  command or pixel byte
//  out_dc     out  1  0 = command, 1 = data
//  busy       out  1  high from the cycle after an accepted start until DONE
//  done       out  1  1-cycle pulse at end of request
// BEHAVIOUR
//  Reset: state = IDLE; all outputs 0 (out_valid, out_byte, out_dc, busy, done, char_idx, font_sel, font_row, index).
//  Reset mid-operation aborts the request; out_valid is 0 after the reset edge and nothing is resumed.
//  start while busy is ignored. On start, page/col/num_chars are latched.
//  FSM: IDLE -> CMD_PG -> CMD_CL -> CMD_CH -> FETCH -> LATCH -> DATA -> (FETCH | ROW_END) -> DONE -> IDLE.
//  Every transfer state holds out_valid=1 and keeps out_byte/out_dc stable until out_ready; then it advances.
//  CMD_PG sends 8'hB0|pg; CMD_CL sends 8'h00|col[3:0]; CMD_CH sends 8'h10|col[6:4]. All have out_dc=0.
//  pg = page + font_row. The column counter cc (8 bits) is reloaded with col at the start of each row.
//  FETCH: drive font_sel=char_code, font_row, index=gcol (glyph column). out_valid=0.
//  LATCH: capture font_data into out_byte at the end of this cycle. out_valid=0.
//  DATA: out_dc=1, out_valid=1. On transfer: cc++, gcol++.
//  Glyph end: gcol reaches 7 (narrow) or 15 (wide) -> gcol=0, char_idx++.
//  Minimum cost is 3 cycles per data byte; 1 cycle of out_valid per command byte with out_ready high.
//  Clipping: when cc reaches OLED_COLS, the remaining glyph bytes of that row are skipped (never fetched); go to ROW_END.
//  ROW_END: if font_row=0 and page<7, set font_row=1, char_idx=0, gcol=0 and go to CMD_PG.
//  Otherwise go to DONE. page=7 renders row 0 only.
//  num_chars=0: after start, go directly to DONE (busy for 1 cycle, done pulse, no bytes sent).
//  DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
// CONFIGURATION
//  TAIL_CLEAR_EN defined: after the last glyph of each row, with cc<OLED_COLS, send 0x00 data bytes (out_dc=1)
//   until cc=OLED_COLS. These bytes need no ROM fetch, so they cost 1 cycle each. This clears stale pixels.
//  TAIL_CLEAR_EN undefined: no padding; the row ends after the last glyph byte (or the clip point).
// TESTING
//  1. page=2, col=0x25, chars {F(0,narrow), 之(4,wide)}, out_ready=1 ->
//     B2,05,12 | 08 F8 88 88 E8 08 10 00 | 10 0C 04 84 14 64 05 06 F4 04 04 04 04 14 0C 00 |
//     B3,05,12 | 20 3F 20 00 03 00 00 00 | 04 84 84 44 47 24 14 0C 07 0C 14 24 44 84 04 00 | done.
//  2. Same as 1 with out_ready toggling 1-of-3 cycles -> identical byte sequence; out_byte stable while out_valid & !out_ready.
//  3. col=124, one wide glyph -> per row only 4 data bytes (glyph cols 0..3) after the 3 commands; total 14 transfers.
//  4. page=7, num_chars=1 -> B7, col cmds, 8 or 16 data bytes, done; no B8/B0 page command.
//  5. num_chars=0 -> no out_valid; done 2 cycles after start. start pulsed while busy -> ignored, no second done.
//  6. rst asserted mid-DATA -> next cycle out_valid=0, busy=0; new start renders cleanly.
//     TAIL_CLEAR_EN build, col=0, one narrow glyph -> 8 glyph bytes + 120 bytes of 0x00 per row.

Source files
------------

// File: rtl/oled_string_renderer.sv
// Streams SSD1306 page/column commands followed by font ROM glyph columns for a string of 8- or 16-wide glyphs.
// Build option: define TAIL_CLEAR_EN to pad each row with 0x00 data bytes out to the last display column.
`timescale 1ns/1ps

module oled_string_renderer #(
    parameter int MAX_CHARS = 16,
    parameter int OLED_COLS = 128,
    localparam int CW = $clog2(MAX_CHARS + 1)
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    page,
    input  logic [6:0]    col,
    input  logic [CW-1:0] num_chars,
    output logic [CW-1:0] char_idx,
    input  logic [5:0]    char_code,
    input  logic          char_wide,
    output logic [5:0]    font_sel,
    output logic          font_row,
    output logic [8:0]    index,
    input  logic [7:0]    font_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic          out_dc,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0] COL_LAST = 8'(OLED_COLS - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_PG,
        ST_CMD_CL,
        ST_CMD_CH,
        ST_FETCH,
        ST_LATCH,
        ST_DATA,
        ST_TAIL,
        ST_ROW_END,
        ST_DONE
    } state_t;

    state_t        state_reg;
    logic [2:0]    page_reg;
    logic [6:0]    col_reg;
    logic [CW-1:0] nchars_reg;
    logic [7:0]    cc_reg;
    logic [3:0]    gcol_reg;
    logic          glyph_end_reg;

    logic [CW-1:0] char_idx_reg;
    logic [5:0]    font_sel_reg;
    logic          font_row_reg;
    logic [8:0]    index_reg;
    logic          out_valid_reg;
    logic [7:0]    out_byte_reg;
    logic          out_dc_reg;
    logic          busy_reg;
    logic          done_reg;

    logic       xfer;
    logic [3:0] last_gcol;

    assign xfer      = out_valid_reg & out_ready;
    assign last_gcol = char_wide ? 4'd15 : 4'd7;

    assign char_idx  = char_idx_reg;
    assign font_sel  = font_sel_reg;
    assign font_row  = font_row_reg;
    assign index     = index_reg;
    assign out_valid = out_valid_reg;
    assign out_byte  = out_byte_reg;
    assign out_dc    = out_dc_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            page_reg      <= '0;
            col_reg       <= '0;
            nchars_reg    <= '0;
            cc_reg        <= '0;
            gcol_reg      <= '0;
            glyph_end_reg <= 1'b0;
            char_idx_reg  <= '0;
            font_sel_reg  <= '0;
            font_row_reg  <= 1'b0;
            index_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_byte_reg  <= '0;
            out_dc_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        page_reg     <= page;
                        col_reg      <= col;
                        nchars_reg   <= num_chars;
                        cc_reg       <= {1'b0, col};
                        gcol_reg     <= '0;
                        char_idx_reg <= '0;
                        font_row_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (num_chars == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            out_valid_reg <= 1'b1;
                            out_dc_reg    <= 1'b0;
                            out_byte_reg  <= {5'b10110, page};
                            state_reg     <= ST_CMD_PG;
                        end
                    end
                end
                ST_CMD_PG: begin
                    if (xfer) begin
                        out_byte_reg <= {4'h0, col_reg[3:0]};
                        state_reg    <= ST_CMD_CL;
                    end
                end
                ST_CMD_CL: begin
                    if (xfer) begin
                        out_byte_reg <= {5'b00010, col_reg[6:4]};
                        state_reg    <= ST_CMD_CH;
                    end
                end
                ST_CMD_CH: begin
                    if (xfer) begin
                        out_valid_reg <= 1'b0;
                        font_sel_reg  <= char_code;
                        index_reg     <= {5'd0, gcol_reg};
                        state_reg     <= ST_FETCH;
                    end
                end
                // ROM address is already registered, so font_data is valid during LATCH.
                ST_FETCH: begin
                    state_reg <= ST_LATCH;
                end
                // Glyph bookkeeping is done here so char_code for the next glyph is settled by DATA.
                ST_LATCH: begin
                    out_byte_reg  <= font_data;
                    out_dc_reg    <= 1'b1;
                    out_valid_reg <= 1'b1;
                    if (gcol_reg == last_gcol) begin
                        gcol_reg      <= '0;
                        char_idx_reg  <= char_idx_reg + CW'(1);
                        glyph_end_reg <= 1'b1;
                    end else begin
                        gcol_reg      <= gcol_reg + 4'd1;
                        glyph_end_reg <= 1'b0;
                    end
                    state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (xfer) begin
                        cc_reg <= cc_reg + 8'd1;
                        if (cc_reg == COL_LAST) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_ROW_END;
                        end else if (glyph_end_reg && (char_idx_reg == nchars_reg)) begin
`ifdef TAIL_CLEAR_EN
                            out_byte_reg <= 8'h00;
                            state_reg    <= ST_TAIL;
`else
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_ROW_END;
`endif
                        end else begin
                            out_valid_reg <= 1'b0;
                            font_sel_reg  <= char_code;
                            index_reg     <= {5'd0, gcol_reg};
                            state_reg     <= ST_FETCH;
                        end
                    end
                end
`ifdef TAIL_CLEAR_EN
                ST_TAIL: begin
                    if (xfer) begin
                        cc_reg <= cc_reg + 8'd1;
                        if (cc_reg == COL_LAST) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_ROW_END;
                        end
                    end
                end
`endif
                ST_ROW_END: begin
                    if (!font_row_reg && (page_reg != 3'd7)) begin
                        font_row_reg  <= 1'b1;
                        char_idx_reg  <= '0;
                        gcol_reg      <= '0;
                        cc_reg        <= {1'b0, col_reg};
                        out_valid_reg <= 1'b1;
                        out_dc_reg    <= 1'b0;
                        out_byte_reg  <= {5'b10110, page_reg + 3'd1};
                        state_reg     <= ST_CMD_PG;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_string_renderer.sv
// Directed bench for oled_string_renderer: font ROM and string source models, byte-stream capture, per-scenario checks.
`timescale 1ns/1ps

module tb_oled_string_renderer;

    localparam logic [63:0]  N_R0 = 64'h08_F8_88_88_E8_08_10_00;
    localparam logic [63:0]  N_R1 = 64'h20_3F_20_00_03_00_00_00;
    localparam logic [127:0] W_R0 = 128'h10_0C_04_84_14_64_05_06_F4_04_04_04_04_14_0C_00;
    localparam logic [127:0] W_R1 = 128'h04_84_84_44_47_24_14_0C_07_0C_14_24_44_84_04_00;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] page;
    logic [6:0] col;
    logic [4:0] num_chars;
    logic [4:0] char_idx;
    logic [5:0] char_code;
    logic       char_wide;
    logic [5:0] font_sel;
    logic       font_row;
    logic [8:0] index;
    logic [7:0] font_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_byte;
    logic       out_dc;
    logic       busy;
    logic       done;

    logic [5:0] str_code [32];
    logic       str_wide [32];

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int valid_cycles = 0;

    logic [7:0] cap_byte [$];
    logic       cap_dc   [$];
    logic [7:0] exp_byte [$];
    logic       exp_dc   [$];

    always #5 clk = ~clk;

    oled_string_renderer dut (
        .sys_clk   (clk),
        .rst       (rst),
        .start     (start),
        .page      (page),
        .col       (col),
        .num_chars (num_chars),
        .char_idx  (char_idx),
        .char_code (char_code),
        .char_wide (char_wide),
        .font_sel  (font_sel),
        .font_row  (font_row),
        .index     (index),
        .font_data (font_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_dc    (out_dc),
        .busy      (busy),
        .done      (done)
    );

    assign char_code = str_code[char_idx];
    assign char_wide = str_wide[char_idx];

    function automatic logic [7:0] rom_byte(input logic [5:0] code, input logic row, input logic [8:0] idx);
        logic [63:0]  n;
        logic [127:0] w;
        case (code)
            6'd0: begin
                n = row ? N_R1 : N_R0;
                return n[8*(7 - int'(idx[2:0])) +: 8];
            end
            6'd4: begin
                w = row ? W_R1 : W_R0;
                return w[8*(15 - int'(idx[3:0])) +: 8];
            end
            default: return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) font_data <= rom_byte(font_sel, font_row, index);

    // Drives out_ready and samples the output channel once per cycle on the falling edge.
    initial begin
        int         rcnt;
        logic       hold_pending;
        logic [8:0] hold_val;
        rcnt = 0;
        hold_pending = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            rcnt++;
            out_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
            if (!rst) begin
                if (hold_pending && out_valid) begin
                    checks++;
                    if ({out_dc, out_byte} !== hold_val) begin
                        failures++;
                        $display("FAIL hold_stable got=%h required=%h", {out_dc, out_byte}, hold_val);
                    end
                end
                hold_pending = out_valid && !out_ready;
                hold_val = {out_dc, out_byte};
                if (out_valid && out_ready) begin
                    cap_byte.push_back(out_byte);
                    cap_dc.push_back(out_dc);
                end
                if (out_valid) valid_cycles++;
                if (done) done_cnt++;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    task automatic clear_streams();
        cap_byte.delete();
        cap_dc.delete();
        exp_byte.delete();
        exp_dc.delete();
    endtask

    task automatic exp_cmd(input logic [2:0] pg, input logic [6:0] c);
        exp_byte.push_back(8'hB0 | {5'd0, pg});     exp_dc.push_back(1'b0);
        exp_byte.push_back({4'h0, c[3:0]});         exp_dc.push_back(1'b0);
        exp_byte.push_back(8'h10 | {5'd0, c[6:4]}); exp_dc.push_back(1'b0);
    endtask

    task automatic exp_glyph(input logic [5:0] code, input logic row, input int ncols);
        for (int c = 0; c < ncols; c++) begin
            exp_byte.push_back(rom_byte(code, row, 9'(c)));
            exp_dc.push_back(1'b1);
        end
    endtask

    task automatic exp_tail(input int cc_end);
`ifdef TAIL_CLEAR_EN
        for (int c = cc_end; c < 128; c++) begin
            exp_byte.push_back(8'h00);
            exp_dc.push_back(1'b1);
        end
`else
        if (cc_end > 200) $display("tail end out of range %0d", cc_end);
`endif
    endtask

    task automatic do_start(input logic [2:0] p, input logic [6:0] c, input logic [4:0] n);
        @(negedge clk);
        page = p;
        col = c;
        num_chars = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic build_two_glyphs();
        str_code[0] = 6'd0; str_wide[0] = 1'b0;
        str_code[1] = 6'd4; str_wide[1] = 1'b1;
        exp_cmd(3'd2, 7'h25); exp_glyph(6'd0, 1'b0, 8); exp_glyph(6'd4, 1'b0, 16); exp_tail(61);
        exp_cmd(3'd3, 7'h25); exp_glyph(6'd0, 1'b1, 8); exp_glyph(6'd4, 1'b1, 16); exp_tail(61);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        page = '0;
        col = '0;
        num_chars = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=000", {out_valid, busy, done});
        end
        checks++;
        if ({out_byte, out_dc} !== 9'd0) begin
            failures++;
            $display("FAIL reset_byte got=%h required=000", {out_byte, out_dc});
        end
        checks++;
        if ({char_idx, font_sel, font_row, index} !== 21'd0) begin
            failures++;
            $display("FAIL reset_rom got=%h required=0", {char_idx, font_sel, font_row, index});
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_two_glyphs(input string name);
        bit ok;
        clear_streams();
        build_two_glyphs();
        do_start(3'd2, 7'h25, 5'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy got=%b required=1", name, busy);
        end
        run_until_done(3000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got=no_done required=done", name);
        end
        checks++;
        if (cap_byte.size() != exp_byte.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d required=%0d", name, cap_byte.size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                failures++;
                $display("FAIL %s_byte[%0d] got=%b/%h required=%b/%h", name, i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        $display("%s: %0d transfers captured, %0d expected", name, cap_byte.size(), exp_byte.size());
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        test_two_glyphs("backpressure");
        ready_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_clip();
        bit ok;
        clear_streams();
        str_code[0] = 6'd4; str_wide[0] = 1'b1;
        exp_cmd(3'd0, 7'd124); exp_glyph(6'd4, 1'b0, 4);
        exp_cmd(3'd1, 7'd124); exp_glyph(6'd4, 1'b1, 4);
        do_start(3'd0, 7'd124, 5'd1);
        run_until_done(1000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL clip_timeout got=no_done required=done");
        end
        checks++;
        if (cap_byte.size() != 14) begin
            failures++;
            $display("FAIL clip_len got=%0d required=14", cap_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                failures++;
                $display("FAIL clip_byte[%0d] got=%b/%h required=%b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        $display("clip: %0d transfers captured", cap_byte.size());
    endtask

    task automatic test_last_page();
        bit ok;
        clear_streams();
        str_code[0] = 6'd0; str_wide[0] = 1'b0;
        exp_cmd(3'd7, 7'd0); exp_glyph(6'd0, 1'b0, 8); exp_tail(8);
        do_start(3'd7, 7'd0, 5'd1);
        run_until_done(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL last_page_timeout got=no_done required=done");
        end
        repeat (5) @(negedge clk);
        checks++;
        if (cap_byte.size() != exp_byte.size()) begin
            failures++;
            $display("FAIL last_page_len got=%0d required=%0d", cap_byte.size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                failures++;
                $display("FAIL last_page_byte[%0d] got=%b/%h required=%b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        $display("last_page: %0d transfers captured", cap_byte.size());
    endtask

    task automatic test_zero_chars();
        int v0;
        v0 = valid_cycles;
        do_start(3'd3, 7'd10, 5'd0);
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL zero_cycle1 got=%b required=10", {busy, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b01) begin
            failures++;
            $display("FAIL zero_cycle2 got=%b required=01", {busy, done});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse got=%b required=0", done);
        end
        checks++;
        if (valid_cycles != v0) begin
            failures++;
            $display("FAIL zero_no_valid got=%0d required=%0d", valid_cycles, v0);
        end
        $display("zero_chars: request complete");
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int d0;
        clear_streams();
        str_code[0] = 6'd0; str_wide[0] = 1'b0;
        exp_cmd(3'd0, 7'd0); exp_glyph(6'd0, 1'b0, 8); exp_tail(8);
        exp_cmd(3'd1, 7'd0); exp_glyph(6'd0, 1'b1, 8); exp_tail(8);
        d0 = done_cnt;
        do_start(3'd0, 7'd0, 5'd1);
        repeat (4) @(negedge clk);
        do_start(3'd5, 7'd50, 5'd0);
        run_until_done(3000, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL busy_start_done_count got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (cap_byte.size() != exp_byte.size()) begin
            failures++;
            $display("FAIL busy_start_len got=%0d required=%0d", cap_byte.size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                failures++;
                $display("FAIL busy_start_byte[%0d] got=%b/%h required=%b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        $display("start_while_busy: %0d transfers captured", cap_byte.size());
    endtask

    task automatic test_reset_mid();
        bit found;
        str_code[0] = 6'd0; str_wide[0] = 1'b0;
        do_start(3'd1, 7'd0, 5'd1);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid && out_dc) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_mid_reach_data got=0 required=1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_abort got=%b required=00", {out_valid, busy});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_resume got=%b required=0", out_valid);
        end
        $display("reset_mid: abort observed");
        test_two_glyphs("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            str_code[i] = 6'd63;
            str_wide[i] = 1'b0;
        end
        test_reset();
        test_two_glyphs("two_glyphs");
        test_backpressure();
        test_clip();
        test_last_page();
        test_zero_chars();
        test_start_while_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
